// File: rtl/sd_cmd_arbiter_if.sv
// Bundle between the sector reader, the sector writer, the SD command core and the DAT0 pad.
// The arbiter connects through the slave modport and the surrounding logic through the master modport.
interface sd_cmd_arbiter_if;
  localparam int unsigned PRECNT_W = 16;
  localparam int unsigned CMD_W    = 6;
  localparam int unsigned ARG_W    = 32;
  localparam int unsigned CLKDIV_W = 16;

  logic                rd_init_done;
  logic                rd_req;
  logic                rd_start;
  logic [PRECNT_W-1:0] rd_precnt;
  logic [CMD_W-1:0]    rd_cmd;
  logic [ARG_W-1:0]    rd_arg;
  logic [CLKDIV_W-1:0] rd_clkdiv;

  logic                wr_req;
  logic                wr_start;
  logic [PRECNT_W-1:0] wr_precnt;
  logic [CMD_W-1:0]    wr_cmd;
  logic [ARG_W-1:0]    wr_arg;
  logic [CLKDIV_W-1:0] wr_clkdiv;
  logic                wr_dat_o;

  logic rd_gnt, wr_gnt;
  logic rd_busy, wr_busy;
  logic rd_done, wr_done;
  logic rd_timeout, wr_timeout;
  logic rd_syntaxe, wr_syntaxe;
  logic [ARG_W-1:0] resparg;

  logic                start;
  logic [PRECNT_W-1:0] precnt;
  logic [CMD_W-1:0]    cmd;
  logic [ARG_W-1:0]    arg;
  logic [CLKDIV_W-1:0] clkdiv;
  logic                busy, done, timeout, syntaxe;
  logic [ARG_W-1:0]    core_resparg;

  logic sddat0_o;
  logic sddat0_oe;
  logic hold_err;

  modport slave (
    input  rd_init_done, rd_req, rd_start, rd_precnt, rd_cmd, rd_arg, rd_clkdiv,
    input  wr_req, wr_start, wr_precnt, wr_cmd, wr_arg, wr_clkdiv, wr_dat_o,
    output rd_gnt, wr_gnt, rd_busy, wr_busy, rd_done, wr_done,
    output rd_timeout, wr_timeout, rd_syntaxe, wr_syntaxe, resparg,
    output start, precnt, cmd, arg, clkdiv,
    input  busy, done, timeout, syntaxe, core_resparg,
    output sddat0_o, sddat0_oe, hold_err
  );

  modport master (
    output rd_init_done, rd_req, rd_start, rd_precnt, rd_cmd, rd_arg, rd_clkdiv,
    output wr_req, wr_start, wr_precnt, wr_cmd, wr_arg, wr_clkdiv, wr_dat_o,
    input  rd_gnt, wr_gnt, rd_busy, wr_busy, rd_done, wr_done,
    input  rd_timeout, wr_timeout, rd_syntaxe, wr_syntaxe, resparg,
    input  start, precnt, cmd, arg, clkdiv,
    output busy, done, timeout, syntaxe, core_resparg,
    output sddat0_o, sddat0_oe, hold_err
  );
endinterface

// File: rtl/sd_cmd_arbiter.sv
// Locks the SD command core and DAT0 pad to one of reader/writer per transaction,
// gating status to the non-owner and force-releasing a grant held too long.
module sd_cmd_arbiter #(
  parameter logic [31:0] HOLD_MAX    = 32'd8_000_000,
  parameter logic [15:0] INIT_CLKDIV = 16'd96
) (
  input logic               clk,
  input logic               rstn,
  sd_cmd_arbiter_if.slave   bus
);

  localparam int unsigned HOLD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GNT_RD  = 2'd1,
    S_GNT_WR  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              last_wr_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              rd_lock_q, wr_lock_q;
  logic              hold_err_q;

  logic rd_elig, wr_elig, hold_hit;
  logic grant_rd, grant_wr, force_rel;

  assign rd_elig  = bus.rd_req & ~rd_lock_q;
  assign wr_elig  = bus.wr_req & bus.rd_init_done & ~wr_lock_q;
  assign hold_hit = (hold_cnt_q == HOLD_MAX);

  // State register plus grant bookkeeping, watchdog and lockouts
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      last_wr_q  <= 1'b1;
      hold_cnt_q <= '0;
      rd_lock_q  <= 1'b0;
      wr_lock_q  <= 1'b0;
      hold_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_err_q <= force_rel;
      if (grant_rd || grant_wr) begin
        last_wr_q  <= grant_wr;
        hold_cnt_q <= '0;
      end else if (state_q == S_GNT_RD || state_q == S_GNT_WR) begin
        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
      end
      if (force_rel && state_q == S_GNT_RD) rd_lock_q <= 1'b1;
      else if (!bus.rd_req)                 rd_lock_q <= 1'b0;
      if (force_rel && state_q == S_GNT_WR) wr_lock_q <= 1'b1;
      else if (!bus.wr_req)                 wr_lock_q <= 1'b0;
    end
  end

  // Next-state: alternate on contention, hold while owner busy, watchdog overrides busy
  always_comb begin
    state_d   = state_q;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    force_rel = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rd_elig && wr_elig) begin
          grant_rd = last_wr_q;
          grant_wr = ~last_wr_q;
        end else begin
          grant_rd = rd_elig;
          grant_wr = wr_elig;
        end
        if (grant_rd)      state_d = S_GNT_RD;
        else if (grant_wr) state_d = S_GNT_WR;
      end
      S_GNT_RD: begin
        if (hold_hit) begin
          force_rel = 1'b1;
          state_d   = S_RELEASE;
        end else if (!bus.rd_req && !bus.busy) begin
          state_d = S_RELEASE;
        end
      end
      S_GNT_WR: begin
        if (hold_hit) begin
          force_rel = 1'b1;
          state_d   = S_RELEASE;
        end else if (!bus.wr_req && !bus.busy) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state; non-owners see a busy, silent core
  always_comb begin
    bus.rd_gnt     = 1'b0;
    bus.wr_gnt     = 1'b0;
    bus.rd_busy    = 1'b1;
    bus.wr_busy    = 1'b1;
    bus.rd_done    = 1'b0;
    bus.wr_done    = 1'b0;
    bus.rd_timeout = 1'b0;
    bus.wr_timeout = 1'b0;
    bus.rd_syntaxe = 1'b0;
    bus.wr_syntaxe = 1'b0;
    bus.resparg    = bus.core_resparg;
    bus.start      = 1'b0;
    bus.precnt     = '0;
    bus.cmd        = '0;
    bus.arg        = '0;
    bus.clkdiv     = INIT_CLKDIV;
    bus.sddat0_oe  = 1'b0;
    bus.sddat0_o   = 1'b1;
    bus.hold_err   = hold_err_q;
    unique case (state_q)
      S_GNT_RD: begin
        bus.rd_gnt     = 1'b1;
        bus.rd_busy    = bus.busy;
        bus.rd_done    = bus.done;
        bus.rd_timeout = bus.timeout;
        bus.rd_syntaxe = bus.syntaxe;
        bus.start      = bus.rd_start;
        bus.precnt     = bus.rd_precnt;
        bus.cmd        = bus.rd_cmd;
        bus.arg        = bus.rd_arg;
        bus.clkdiv     = bus.rd_clkdiv;
      end
      S_GNT_WR: begin
        bus.wr_gnt     = 1'b1;
        bus.wr_busy    = bus.busy;
        bus.wr_done    = bus.done;
        bus.wr_timeout = bus.timeout;
        bus.wr_syntaxe = bus.syntaxe;
        bus.start      = bus.wr_start;
        bus.precnt     = bus.wr_precnt;
        bus.cmd        = bus.wr_cmd;
        bus.arg        = bus.wr_arg;
        bus.clkdiv     = bus.wr_clkdiv;
        bus.sddat0_oe  = 1'b1;
        bus.sddat0_o   = bus.wr_dat_o;
      end
      default: ;
    endcase
  end

endmodule
